// File: rtl/msg_decrypt_engine.sv
// msg_decrypt_engine: recovers the LFSR key from a space preamble and
// decrypts 64 bytes held in the shared data memory.
module msg_decrypt_engine #(
  parameter int unsigned HDR_BYTES  = 8,
  parameter logic [7:0]  CRYPT_BASE = 8'd64,
  parameter logic [7:0]  PLAIN_BASE = 8'd0
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  output logic       Ack,
  output logic [7:0] mem_addr,
  output logic       mem_wr_en,
  output logic [7:0] mem_wr_data,
  input  logic [7:0] mem_rd_data,
  output logic [3:0] pt_found,
  output logic [6:0] lfsr_found,
  output logic [7:0] pre_found,
  output logic [6:0] parity_err,
  output logic       err
);

  localparam logic [3:0] HDR_N = 4'(HDR_BYTES);
  localparam logic [6:0] SP7   = 7'h20;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_SEARCH,
    S_DECRYPT,
    S_PAD,
    S_DONE
  } state_e;

  state_e     state_q;
  logic [3:0] cnt_q;
  logic [3:0] k_q;
  logic [5:0] i_q;
  logic       phase_q;
  logic [6:0] w_q;
  logic       skip_q;
  logic [6:0] lfsr_q;
  logic [7:0] hdr_q [HDR_BYTES];
  logic       ack_q;
  logic       err_q;
  logic [3:0] pt_q;
  logic [6:0] lf_q;
  logic [7:0] pre_q;
  logic [6:0] par_q;

  function automatic logic [6:0] tap_rom(input logic [3:0] k);
    case (k)
      4'd0:    tap_rom = 7'h60;
      4'd1:    tap_rom = 7'h48;
      4'd2:    tap_rom = 7'h78;
      4'd3:    tap_rom = 7'h72;
      4'd4:    tap_rom = 7'h6A;
      4'd5:    tap_rom = 7'h69;
      4'd6:    tap_rom = 7'h5C;
      4'd7:    tap_rom = 7'h7E;
      4'd8:    tap_rom = 7'h7B;
      default: tap_rom = 7'h00;
    endcase
  endfunction

  function automatic logic [6:0] lfsr_step(
    input logic [6:0] l,
    input logic [6:0] t
  );
    lfsr_step = {l[5:0], ^(l & t)};
  endfunction

  // Candidate k is checked against the whole header in one cycle
  logic [6:0] l0_d;
  logic [6:0] srch_l;
  logic       match_d;

  always_comb begin
    l0_d    = hdr_q[0][6:0] ^ SP7;
    match_d = 1'b1;
    srch_l  = l0_d;
    for (int j = 1; j < int'(HDR_BYTES); j++) begin
      srch_l = lfsr_step(srch_l, tap_rom(k_q));
      if (srch_l != (hdr_q[j][6:0] ^ SP7)) match_d = 1'b0;
    end
  end

  logic [7:0] plain_d;
  logic       par_bad_d;
  logic       keep_d;
  logic [6:0] w_inc_d;

  always_comb begin
    plain_d   = {1'b0, mem_rd_data[6:0] ^ lfsr_q};
    par_bad_d = mem_rd_data[7] != ^mem_rd_data[6:0];
    keep_d    = !(skip_q && plain_d == 8'h20);
    w_inc_d   = w_q + {6'd0, keep_d};
  end

  // Second decrypt cycle writes straight from the returned read data
  always_comb begin
    mem_addr    = 8'h00;
    mem_wr_en   = 1'b0;
    mem_wr_data = 8'h00;
    case (state_q)
      S_HDR: begin
        if (cnt_q < HDR_N) mem_addr = CRYPT_BASE + {4'd0, cnt_q};
      end
      S_DECRYPT: begin
        mem_addr = CRYPT_BASE + {2'd0, i_q};
        if (phase_q && keep_d) begin
          mem_addr    = PLAIN_BASE + {1'b0, w_q};
          mem_wr_en   = 1'b1;
          mem_wr_data = plain_d;
        end
      end
      S_PAD: begin
        mem_addr    = PLAIN_BASE + {1'b0, w_q};
        mem_wr_en   = 1'b1;
        mem_wr_data = 8'h20;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      k_q     <= 4'd0;
      i_q     <= 6'd0;
      phase_q <= 1'b0;
      w_q     <= 7'd0;
      skip_q  <= 1'b0;
      lfsr_q  <= 7'd0;
      for (int n = 0; n < int'(HDR_BYTES); n++) hdr_q[n] <= 8'h00;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      pt_q    <= 4'd0;
      lf_q    <= 7'd0;
      pre_q   <= 8'd0;
      par_q   <= 7'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!Start) begin
            state_q <= S_HDR;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
            pt_q    <= 4'd0;
            lf_q    <= 7'd0;
            pre_q   <= 8'd0;
            par_q   <= 7'd0;
          end
        end
        S_HDR: begin
          for (int n = 0; n < int'(HDR_BYTES); n++) begin
            if (cnt_q == 4'(n + 1)) hdr_q[n] <= mem_rd_data;
          end
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == HDR_N) begin
            state_q <= S_SEARCH;
            k_q     <= 4'd0;
          end
        end
        S_SEARCH: begin
          if (l0_d == 7'd0) begin
            err_q   <= 1'b1;
            ack_q   <= 1'b1;
            state_q <= S_DONE;
          end else if (match_d) begin
            pt_q    <= k_q;
            lf_q    <= l0_d;
            lfsr_q  <= l0_d;
            i_q     <= 6'd0;
            phase_q <= 1'b0;
            w_q     <= 7'd0;
            skip_q  <= 1'b1;
            state_q <= S_DECRYPT;
          end else if (k_q == 4'd8) begin
            err_q   <= 1'b1;
            ack_q   <= 1'b1;
            state_q <= S_DONE;
          end else begin
            k_q <= k_q + 4'd1;
          end
        end
        S_DECRYPT: begin
          phase_q <= !phase_q;
          if (phase_q) begin
            lfsr_q <= lfsr_step(lfsr_q, tap_rom(pt_q));
            if (par_bad_d && par_q != 7'h7F) par_q <= par_q + 7'd1;
            if (keep_d) begin
              skip_q <= 1'b0;
              w_q    <= w_inc_d;
            end else begin
              pre_q <= pre_q + 8'd1;
            end
            i_q <= i_q + 6'd1;
            if (i_q == 6'd63) begin
              if (w_inc_d == 7'd64) begin
                state_q <= S_DONE;
                ack_q   <= 1'b1;
              end else begin
                state_q <= S_PAD;
              end
            end
          end
        end
        S_PAD: begin
          w_q <= w_q + 7'd1;
          if (w_q == 7'd63) begin
            state_q <= S_DONE;
            ack_q   <= 1'b1;
          end
        end
        S_DONE: begin
          if (Start) begin
            state_q <= S_IDLE;
            ack_q   <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Ack        = ack_q;
  assign err        = err_q;
  assign pt_found   = pt_q;
  assign lfsr_found = lf_q;
  assign pre_found  = pre_q;
  assign parity_err = par_q;

endmodule
